pipelined_approx_adder: RTL and testbench
=========================================

PIPELINED_APPROX_ADDER -- requirements
Module: pipelined_approx_adder

Interface
REQ-001 Parameter N, default 16: operand and sum width in bits.
REQ-002 Parameter K, default 4: number of LSBs (bits 0..K-1) using approximate cells when approximate mode is on. Legal range 0..N.
REQ-003 Parameter S, default 2: number of pipeline stages. Legal only if S >= 1 and N % S == 0. Each stage covers N/S bits.
REQ-004 Parameter CW, default 16: error-counter width.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  operand transfer request.
REQ-008 in_ready  out  1  block can accept operands this cycle.
REQ-009 a, b  in  N each  operands.
REQ-010 cin  in  1  carry-in.
REQ-011 approx_en  in  1  per-transaction mode: 1 = approximate LSBs, 0 = exact; captured with the operands.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 sum  out  N  result.
REQ-015 cout  out  1  result carry-out.
REQ-016 err_clr  in  1  synchronous clear of err_cnt.
REQ-017 err_cnt  out  CW  count of delivered approximate results that differ from the exact sum.

Function
REQ-018 Exact cell: sum = a^b^c; carry = ab | ac | bc.
REQ-019 Approximate cell: carry is the exact majority; sum = ~carry.
REQ-020 Cell selection: bit i uses the approximate cell iff approx_en = 1 and i < K; otherwise it uses the exact cell.
REQ-021 Adder structure: ripple-carry within each stage; the stage carry-out is registered and feeds the next stage.
- Operand bits for later stages are delayed alongside the carry.
- Lower sum bits are delayed so that all N bits and cout emerge together.
REQ-022 Latency with no stall: a transfer accepted on edge t is presented with out_valid = 1 after edge t+S-1.
- Example: S = 1 shows the result the cycle after acceptance.
REQ-023 Each stage carries a valid bit. Pipeline advance enable: adv = out_ready | ~out_valid.
REQ-024 in_ready = adv.
- A transfer occurs on an edge where in_valid & in_ready.
- When in_valid = 0 and adv = 1, a bubble (valid = 0) enters stage 1.
REQ-025 When adv = 0 (stall):
- all stage registers, including sum, cout and out_valid, hold their values;
- in_ready = 0;
- a, b, cin and approx_en are ignored.
REQ-026 Throughput: one result per cycle when in_valid = 1 and out_ready = 1 continuously. No bubbles are inserted.
REQ-027 An exact shadow sum is computed for every transaction (same pipeline, exact cells only) and carried with it.
REQ-028 err_cnt increments by 1 on an edge where all of the following hold:
- out_valid & out_ready;
- the transaction had approx_en = 1;
- {cout, sum} differs from the shadow {cout, sum}.
REQ-029 err_cnt saturates at 2^CW-1 and does not wrap.
REQ-030 err_clr = 1 sets err_cnt to 0 on that edge. Clear wins over a simultaneous increment.
REQ-031 Arithmetic is modulo 2^N on sum, with overflow reported only on cout. There is no sign handling.
REQ-032 With K = 0 or approx_en = 0, {cout, sum} shall equal a + b + cin exactly, and err_cnt shall never increment.
REQ-033 sum and cout are don't-care while out_valid = 0, but shall only change on an edge where adv = 1.

Reset
REQ-034 rst_n low shall immediately clear:
- all stage valid bits;
- out_valid;
- sum, cout, carry and pipeline registers;
- err_cnt.
REQ-035 While rst_n is low, in_ready shall be 1 (out_valid = 0 implies adv = 1), but no transfer is captured.
REQ-036 Reset asserted mid-operation discards all in-flight transactions. None are delivered after release.
REQ-037 After rst_n deasserts, the first edge may accept a transfer.

Verification
REQ-038 Exact add, N=16, K=4, S=2: a=0x1234, b=0x0F0F, cin=0, approx_en=0 -> sum=0x2143, cout=0, out_valid 2 edges after acceptance; err_cnt=0.
REQ-039 Approximate error: a=0x0001, b=0x0001, cin=0, approx_en=1 -> sum=0x000E, cout=0; err_cnt 0 -> 1 on the output handshake.
REQ-040 Approximate no-error: a=0x1234, b=0x0F0F, approx_en=1 -> sum=0x2143; err_cnt unchanged.
REQ-041 Back-pressure sequence:
- Stimulus: stream 8 random transfers; hold out_ready=0 for 3 cycles mid-stream.
- Required: sum and out_valid stable during the stall; in_ready=0 while out_valid=1 and out_ready=0; all 8 results delivered in order with none lost or duplicated.
REQ-042 Overflow: a=0xFFFF, b=0x0001, cin=1, approx_en=0 -> sum=0x0001, cout=1.
REQ-043 Boundary, CW=2: force 4 error transactions -> err_cnt stays at 3. Assert err_clr together with a 5th error delivery -> err_cnt = 0. Assert rst_n low with 2 transactions in flight -> out_valid = 0 immediately, and nothing is delivered after release.

Source files
------------

// File: rtl/pipelined_approx_adder.sv
// Pipelined ripple-carry adder with per-transaction approximate low bits.
// An exact shadow sum travels with each result so that approximation errors can be counted.
module pipelined_approx_adder #(
    parameter int N  = 16,
    parameter int K  = 4,
    parameter int S  = 2,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          cin,
    input  logic          approx_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  sum,
    output logic          cout,
    input  logic          err_clr,
    output logic [CW-1:0] err_cnt
);

    localparam int W = N / S;

    logic w_adv;

    // Each stage consumes the low W operand bits and rotates its W result bits in at the top.
    // After S stages the a-path holds the delivered sum and the b-path holds the exact shadow sum.
    for (genvar s = 0; s < S; s++) begin : g_stg
        logic [N-1:0] w_ain;
        logic [N-1:0] w_bin;
        logic         w_cin;
        logic         w_vin;
        logic         w_apx_in;
        logic [W-1:0] w_sa;
        logic [W-1:0] w_se;
        logic         w_co;
        logic         w_maj;
        logic [N-1:0] w_na;
        logic [N-1:0] w_nb;
        logic [N-1:0] r_a;
        logic [N-1:0] r_b;
        logic         r_c;
        logic         r_vld;
        logic         r_apx;

        if (s == 0) begin : g_head
            assign w_ain    = a;
            assign w_bin    = b;
            assign w_cin    = cin;
            assign w_vin    = in_valid;
            assign w_apx_in = approx_en;
        end else begin : g_body
            assign w_ain    = g_stg[s-1].r_a;
            assign w_bin    = g_stg[s-1].r_b;
            assign w_cin    = g_stg[s-1].r_c;
            assign w_vin    = g_stg[s-1].r_vld;
            assign w_apx_in = g_stg[s-1].r_apx;
        end

        // The approximate cell keeps the exact majority carry, so one carry chain serves both sums.
        always_comb begin
            w_co  = w_cin;
            w_maj = 1'b0;
            w_sa  = '0;
            w_se  = '0;
            for (int j = 0; j < W; j++) begin
                w_maj = (w_ain[j] & w_bin[j]) | (w_ain[j] & w_co) | (w_bin[j] & w_co);
                w_se[j] = w_ain[j] ^ w_bin[j] ^ w_co;
                w_sa[j] = (w_apx_in && ((s * W + j) < K)) ? ~w_maj : w_se[j];
                w_co = w_maj;
            end
        end

        if (S == 1) begin : g_single
            assign w_na = w_sa;
            assign w_nb = w_se;
        end else begin : g_rotate
            assign w_na = {w_sa, w_ain[N-1:W]};
            assign w_nb = {w_se, w_bin[N-1:W]};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_a   <= '0;
                r_b   <= '0;
                r_c   <= 1'b0;
                r_vld <= 1'b0;
                r_apx <= 1'b0;
            end else if (w_adv) begin
                r_a   <= w_na;
                r_b   <= w_nb;
                r_c   <= w_co;
                r_vld <= w_vin;
                r_apx <= w_apx_in;
            end
        end
    end

    assign out_valid = g_stg[S-1].r_vld;
    assign sum       = g_stg[S-1].r_a;
    assign cout      = g_stg[S-1].r_c;
    assign w_adv     = out_ready | ~out_valid;
    assign in_ready  = w_adv;

    // Shadow carry-out always equals cout, so only the sum bits can differ.
    logic w_err_hit;
    assign w_err_hit = out_valid & out_ready & g_stg[S-1].r_apx
                     & (g_stg[S-1].r_a != g_stg[S-1].r_b);

    logic [CW-1:0] r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= '0;
        end else if (err_clr) begin
            r_err <= '0;
        end else if (w_err_hit && (r_err != {CW{1'b1}})) begin
            r_err <= r_err + 1'b1;
        end
    end

    assign err_cnt = r_err;

endmodule

// File: tb/tb_pipelined_approx_adder.sv
// Directed bench for pipelined_approx_adder (N=16, K=4, S=2, CW=2).
// Expected values are hand-computed; the back-pressure stream uses exact a+b+cin.
module tb_pipelined_approx_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        approx_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        err_clr = 1'b0;
    logic [1:0]  err_cnt;

    int n_chk = 0;
    int n_fail = 0;

    pipelined_approx_adder #(.N(16), .K(4), .S(2), .CW(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .approx_en(approx_en),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One transaction with an idle output: accept, check latency, check result, check err_cnt.
    task automatic send_one(input string tag, input logic [15:0] a_v, input logic [15:0] b_v,
                            input logic cin_v, input logic apx_v, input logic [15:0] exp_sum,
                            input logic exp_cout, input logic [1:0] exp_err, input logic clr_at_out);
        @(negedge clk);
        in_valid = 1'b1; a = a_v; b = b_v; cin = cin_v; approx_en = apx_v; out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; approx_en = 1'b0;
        chk({tag, "_lat_early"}, out_valid, 0);
        @(negedge clk);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_cout"}, cout, exp_cout);
        err_clr = clr_at_out;
        @(negedge clk);
        err_clr = 1'b0;
        chk({tag, "_err"}, err_cnt, exp_err);
    endtask

    logic [15:0] bp_a [8] = '{16'h1111, 16'hFFFF, 16'h8000, 16'h0F0F, 16'hABCD, 16'h0000, 16'h7FFF, 16'h5555};
    logic [15:0] bp_b [8] = '{16'h2222, 16'h0001, 16'h8000, 16'hF0F0, 16'h1234, 16'h0000, 16'h0001, 16'hAAAA};
    logic        bp_c [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        logic [16:0] bp_exp [8];
        logic [15:0] snap_sum;
        logic        snap_v;
        int          n_in;
        int          n_out;
        int          n_late;

        for (int i = 0; i < 8; i++)
            bp_exp[i] = {1'b0, bp_a[i]} + {1'b0, bp_b[i]} + {16'd0, bp_c[i]};

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send_one("exact_basic",   16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 2'd0, 1'b0);
        send_one("overflow",      16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 2'd0, 1'b0);
        send_one("exact_stage_cy", 16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0100, 1'b0, 2'd0, 1'b0);
        send_one("apx_noerr",     16'h1234, 16'h0F0F, 1'b0, 1'b1, 16'h2143, 1'b0, 2'd0, 1'b0);
        send_one("apx_err_1p1",   16'h0001, 16'h0001, 1'b0, 1'b1, 16'h000E, 1'b0, 2'd1, 1'b0);
        send_one("apx_err_cross", 16'h0080, 16'h0080, 1'b0, 1'b1, 16'h010F, 1'b0, 2'd2, 1'b0);
        send_one("exact_no_inc",  16'h0008, 16'h0008, 1'b0, 1'b0, 16'h0010, 1'b0, 2'd2, 1'b0);

        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr_idle", err_cnt, 0);

        send_one("sat1", 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h000E, 1'b0, 2'd1, 1'b0);
        send_one("sat2", 16'h0008, 16'h0008, 1'b0, 1'b1, 16'h0017, 1'b0, 2'd2, 1'b0);
        send_one("sat3", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h000F, 1'b0, 2'd3, 1'b0);
        send_one("sat4", 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h000E, 1'b0, 2'd3, 1'b0);
        send_one("clr_wins", 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h000E, 1'b0, 2'd0, 1'b1);

        // Back-pressure stream: out_ready low for three cycles mid-stream
        n_in = 0;
        n_out = 0;
        snap_sum = '0;
        snap_v = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            #1;
            if (cyc == 4) begin
                snap_sum = sum;
                snap_v = out_valid;
                chk("bp_stall_valid", out_valid, 1);
            end
            if (cyc >= 5 && cyc <= 7) begin
                chk("bp_hold_sum", sum, snap_sum);
                chk("bp_hold_valid", out_valid, snap_v);
            end
            if (cyc >= 4 && cyc <= 6)
                chk("bp_in_ready_low", in_ready, 0);
            if (out_valid && out_ready) begin
                if (n_out < 8)
                    chk($sformatf("bp_data%0d", n_out), {cout, sum}, bp_exp[n_out]);
                n_out++;
            end
            if (n_in < 8) begin
                in_valid = 1'b1; a = bp_a[n_in]; b = bp_b[n_in]; cin = bp_c[n_in]; approx_en = 1'b0;
                if (in_ready) n_in++;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk("bp_sent", n_in, 8);
        chk("bp_delivered", n_out, 8);

        // Reset with two transactions in flight
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'h0101; b = 16'h0202; cin = 1'b0; approx_en = 1'b0;
        @(negedge clk);
        a = 16'h0303; b = 16'h0404;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_in_ready", in_ready, 1);
        in_valid = 1'b1; a = 16'h0505; b = 16'h0606;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b1;
        n_late = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (out_valid) n_late++;
        end
        chk("rst_no_delivery", n_late, 0);
        chk("rst_err_zero", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
